// File: rtl/la_zip_busarb.sv
// Round-robin Wishbone-style arbiter: one downstream port shared by NM masters,
// grant locked for the whole bus cycle, outstanding requests capped by a counter.
module la_zip_busarb #(
    parameter int NM           = 4,
    parameter int AW           = 32,
    parameter int DW           = 38,
    parameter int LGMAXBURST   = 4,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    output logic [NM-1:0]    o_mstall,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    output logic [NM-1:0]    o_mack,
    output logic [NM-1:0]    o_merr,
    output logic             o_cyc,
    output logic             o_stb,
    input  logic             i_stall,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_data,
    input  logic             i_ack,
    input  logic             i_err,
    output logic [NM-1:0]    o_grant
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [LGMAXBURST-1:0] CNT_ONE  = LGMAXBURST'(1);
    localparam logic [LGMAXBURST-1:0] CNT_FULL = {LGMAXBURST{1'b1}};

    typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t                state_r, state_s;
    logic [IW-1:0]         owner_r, owner_s, last_r, last_s, pick_s;
    logic [LGMAXBURST-1:0] cnt_r, cnt_s;
    logic                  owned_s, mcyc_own_s, full_s, inc_s, dec_s;

    // First requester strictly after `last`, wrapping; lowest distance wins.
    function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] req, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = NM; k >= 1; k--) begin
            idx = int'(last) + k;
            idx = (idx >= NM) ? idx - NM : idx;
            if (req[idx]) begin
                pick = idx[IW-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign pick_s     = rr_pick(i_mcyc, last_r);
    assign owned_s    = (state_r == OWNED);
    assign mcyc_own_s = i_mcyc[owner_r];
    assign full_s     = (cnt_r == CNT_FULL);
    assign o_cyc      = owned_s && mcyc_own_s;
    assign o_stb      = owned_s && mcyc_own_s && i_mstb[owner_r] && !full_s;
    assign inc_s      = o_stb && !i_stall;
    assign dec_s      = i_ack || i_err;

    // State, ownership and outstanding-count registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
            owner_r <= '0;
            last_r  <= IW'(NM - 1);
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: arbitrate in IDLE, release (and abort outstanding) on cyc drop.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (|i_mcyc) begin
                    state_s = OWNED;
                    owner_s = pick_s;
                    last_s  = pick_s;
                end else begin
                    state_s = IDLE;
                end
            end
            OWNED: begin
                if (!mcyc_own_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = OWNED;
                end
            end
            default: state_s = IDLE;
        endcase
        // Saturating counter; full already masks the increment through o_stb.
        if (owned_s && !mcyc_own_s) begin
            cnt_s = '0;
        end else if (inc_s && !dec_s) begin
            cnt_s = cnt_r + CNT_ONE;
        end else if (dec_s && !inc_s && (cnt_r != '0)) begin
            cnt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Per-master grant, stall and response routing.
    always_comb begin
        o_grant  = '0;
        o_mstall = '1;
        o_mack   = '0;
        o_merr   = '0;
        if (owned_s) begin
            o_grant[owner_r]  = 1'b1;
            o_mstall[owner_r] = i_stall || full_s;
            o_mack[owner_r]   = i_ack && mcyc_own_s;
            o_merr[owner_r]   = i_err && mcyc_own_s;
        end else begin
            o_grant  = '0;
            o_mstall = '1;
        end
    end

    // Zero-latency forwarding of the owner's address and payload.
    always_comb begin
        if (OPT_LOWPOWER && !o_stb) begin
            o_addr = '0;
            o_data = '0;
        end else begin
            o_addr = i_maddr[owner_r*AW +: AW];
            o_data = i_mdata[owner_r*DW +: DW];
        end
    end
endmodule
